our_packet_dispatch: RTL and testbench
======================================

# our_packet_dispatch

Receive-side classifier between the Ethernet MAC byte stream and the per-type packet handlers. It parses the Ethernet/IPv4/UDP headers of each frame and selects a handler by UDP destination port. It forwards only the UDP payload, as a contiguous byte stream qualified by one per-type enable, to the type ONE handler (enable `ena_one`) or the type TWO handler (`ena_two`). Frames that fail any check are dropped and counted.

## Interface
- `PORT_ONE`, 16'd5001, UDP destination port routed to type ONE
- `PORT_TWO`, 16'd5002, UDP destination port routed to type TWO
- `LOCAL_MAC`, 48'h0200_0000_0001, accepted destination MAC (filter build only)

- `clock` in 1: single clock; all logic on posedge
- `sclr` in 1: reset, synchronous, active-high
- `rx_data` in 8: frame byte from MAC, first byte = destination MAC[47:40]
- `rx_dv` in 1: byte valid. Contiguous high for a whole frame; low ≥1 cycle between frames
- `dout` in/out: out 8, registered copy of `rx_data`
- `ena_one` out 1: `dout` is a type ONE payload byte
- `ena_two` out 1: `dout` is a type TWO payload byte
- `cnt_one` out 16: type ONE frames forwarded, saturating
- `cnt_two` out 16: type TWO frames forwarded, saturating
- `cnt_drop` out 16: frames rejected, saturating
- `cnt_runt` out 16: frames ending before UDP length satisfied, saturating

## Operation
- States: IDLE, HDR, PAYLOAD, DRAIN. 6-bit header counter `hcnt`; 16-bit `remain`.
- IDLE:
  - `rx_dv`=1 → HDR with `hcnt`=1; byte 0 is captured.
- HDR: capture bytes 0–5 (dest MAC), 12–13 (EtherType), 14 (ver/IHL), 23 (protocol), 36–37 (dst port), 38–39 (UDP length).
- At byte 41 the frame is evaluated and accepted only if all of these hold:
  - EtherType = 16'h0800
  - byte 14 = 8'h45
  - protocol = 8'd17
  - dst port = `PORT_ONE` or `PORT_TWO`
  - UDP length > 8
  - MAC filter passes (see Configuration)
- Accepted frame: `remain` = UDP length − 8, → PAYLOAD, increment `cnt_one` or `cnt_two`. Otherwise → DRAIN, increment `cnt_drop`.
- PAYLOAD: each valid byte decrements `remain`. The selected enable is asserted for that byte.
  - When the last byte (`remain`=1) is consumed → DRAIN. This discards padding and FCS.
- DRAIN: wait for `rx_dv`=0, then → IDLE.
- Boundary conditions:
  - `rx_dv`=0 in HDR → IDLE, `cnt_drop`++.
  - `rx_dv`=0 in PAYLOAD with `remain`>0 → IDLE, `cnt_runt`++. The enable deasserts so the handler resets its counter.
- Counters saturate at 16'hFFFF and never wrap.
- At most one of `ena_one`/`ena_two` is high in any cycle.

## Timing
- Latency: 1 cycle.
  - `dout`/`ena_*` in cycle n+1 reflect the byte and decision of cycle n.
  - `dout` updates every cycle regardless of state.
- First byte at cycle 0 → first payload byte on `dout` at cycle 43.
- The enable is held high continuously for exactly UDP length − 8 cycles. It is never gapped inside a frame.
- The enable is low ≥1 cycle between consecutive forwarded frames; this follows from the `rx_dv` gap.
- Reset values: all outputs 0, state IDLE, `hcnt`=0, `remain`=0.
- `sclr` mid-frame: immediate IDLE and enables low next cycle. The remaining bytes of that frame are handled as follows:
  - If `rx_dv` is still high after release, the block enters HDR on the next `rx_dv` high.
  - To avoid mis-parsing, IDLE requires one `rx_dv`=0 cycle after reset before accepting a frame.

## Configuration
- `DISPATCH_MAC_FILTER_EN` defined: accept only destination MAC = `LOCAL_MAC` or 48'hFFFF_FFFF_FFFF; other frames → DRAIN, `cnt_drop`++.
- Undefined: destination MAC is not captured or checked; all MACs accepted.

## Structure
- Shared package `our_eth_pkg`:
  - offsets OFF_ETHERTYPE=12, OFF_VER_IHL=14, OFF_PROTO=23, OFF_DPORT=36, OFF_ULEN=38, HDR_LEN=42
  - constants ETHERTYPE_IPV4, IP_PROTO_UDP
  - dispatch state enum
- Sub-module `our_sat_counter` (16-bit, inc, sclr), instantiated four times.

## Test plan
- Type ONE frame, dport 5001, UDP length 532 → `ena_one` high cycles 43–566 (524 bytes), `dout` = payload, `cnt_one`=1, `ena_two` never high.
- Back-to-back frames for 5002 then 5001, gap 1 cycle → `ena_two` burst, then ≥1 low cycle, then `ena_one` burst; `cnt_two`=`cnt_one`=1.
- Frame with protocol 6, or EtherType 16'h86DD → no enable, `cnt_drop`=1; a following valid frame is forwarded normally.
- UDP length 532 but `rx_dv` drops after payload byte 300 → `ena_one` high 300 cycles then low, `cnt_runt`=1.
- Frame with 4 trailing FCS bytes after payload → enable covers payload only, FCS not forwarded.
- With `DISPATCH_MAC_FILTER_EN`: dest MAC 02:00:00:00:00:02 → dropped, `cnt_drop`++; broadcast MAC → forwarded.

Source files
------------

// File: rtl/our_eth_pkg.sv
// Shared Ethernet/IPv4/UDP header offsets, constants and dispatch state.
// Used by the receive-side packet dispatcher and its helpers.
package our_eth_pkg;

    localparam logic [5:0] OFF_ETHERTYPE = 6'd12;
    localparam logic [5:0] OFF_VER_IHL   = 6'd14;
    localparam logic [5:0] OFF_PROTO     = 6'd23;
    localparam logic [5:0] OFF_DPORT     = 6'd36;
    localparam logic [5:0] OFF_ULEN      = 6'd38;
    localparam logic [5:0] HDR_LEN       = 6'd42;
    localparam logic [5:0] MAC_LEN       = 6'd6;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

    localparam logic [15:0] PORT_ONE  = 16'd5001;
    localparam logic [15:0] PORT_TWO  = 16'd5002;
    localparam logic [47:0] LOCAL_MAC = 48'h0200_0000_0001;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DRAIN
    } dispatch_state_e;

endpackage

// File: rtl/our_packet_dispatch_if.sv
// MAC byte stream in, registered byte plus per-type enables out.
// master drives the frame bytes; slave is the dispatcher.
interface our_packet_dispatch_if;

    logic [7:0] rx_data;
    logic       rx_dv;
    logic [7:0] dout;
    logic       ena_one;
    logic       ena_two;

    modport master (
        output rx_data,
        output rx_dv,
        input  dout,
        input  ena_one,
        input  ena_two
    );

    modport slave (
        input  rx_data,
        input  rx_dv,
        output dout,
        output ena_one,
        output ena_two
    );

endinterface

// File: rtl/our_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module our_sat_counter (
    input  logic        clock,
    input  logic        sclr,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/our_packet_dispatch.sv
// Parses Ethernet/IPv4/UDP headers and forwards UDP payload by dst port.
// Define DISPATCH_MAC_FILTER_EN to accept only LOCAL_MAC or broadcast.
module our_packet_dispatch
    import our_eth_pkg::*;
(
    input  logic                  clock,
    input  logic                  sclr,
    our_packet_dispatch_if.slave  io,
    output logic [15:0]           cnt_one,
    output logic [15:0]           cnt_two,
    output logic [15:0]           cnt_drop,
    output logic [15:0]           cnt_runt
);

    dispatch_state_e state_q, state_d;
    logic [5:0]  hcnt_q, hcnt_d;
    logic [15:0] remain_q, remain_d;
    logic [15:0] etype_q, etype_d;
    logic [15:0] dport_q, dport_d;
    logic [15:0] ulen_q, ulen_d;
    logic [7:0]  ver_ihl_q, ver_ihl_d;
    logic [7:0]  proto_q, proto_d;
    logic        sel_two_q, sel_two_d;
    logic        armed_q, armed_d;
    logic [7:0]  dout_q, dout_d;
    logic        ena_one_q, ena_one_d;
    logic        ena_two_q, ena_two_d;

    logic inc_one, inc_two, inc_drop, inc_runt;
    logic port_one, port_two, mac_ok, hdr_ok;

`ifdef DISPATCH_MAC_FILTER_EN
    logic [47:0] mac_q, mac_d;
    assign mac_ok = (mac_q == LOCAL_MAC) || (mac_q == BCAST_MAC);
`else
    assign mac_ok = 1'b1;
`endif

    assign port_one = (dport_q == PORT_ONE);
    assign port_two = (dport_q == PORT_TWO);
    assign hdr_ok   = (etype_q == ETHERTYPE_IPV4)
                   && (ver_ihl_q == IPV4_VER_IHL)
                   && (proto_q == IP_PROTO_UDP)
                   && (port_one || port_two)
                   && (ulen_q > UDP_HDR_LEN)
                   && mac_ok;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        remain_d  = remain_q;
        etype_d   = etype_q;
        dport_d   = dport_q;
        ulen_d    = ulen_q;
        ver_ihl_d = ver_ihl_q;
        proto_d   = proto_q;
        sel_two_d = sel_two_q;
        // A frame already in flight at reset release is skipped whole.
        armed_d   = armed_q | ~io.rx_dv;
        dout_d    = io.rx_data;
        ena_one_d = 1'b0;
        ena_two_d = 1'b0;
        inc_one   = 1'b0;
        inc_two   = 1'b0;
        inc_drop  = 1'b0;
        inc_runt  = 1'b0;
`ifdef DISPATCH_MAC_FILTER_EN
        mac_d     = mac_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (io.rx_dv && armed_q) begin
                    state_d = ST_HDR;
                    hcnt_d  = 6'd1;
`ifdef DISPATCH_MAC_FILTER_EN
                    mac_d   = {mac_q[39:0], io.rx_data};
`endif
                end
            end
            ST_HDR: begin
                if (!io.rx_dv) begin
                    state_d  = ST_IDLE;
                    hcnt_d   = 6'd0;
                    inc_drop = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 6'd1;
`ifdef DISPATCH_MAC_FILTER_EN
                    if (hcnt_q < MAC_LEN) begin
                        mac_d = {mac_q[39:0], io.rx_data};
                    end
`endif
                    unique case (1'b1)
                        hcnt_q == OFF_ETHERTYPE,
                        hcnt_q == OFF_ETHERTYPE + 6'd1:
                            etype_d = {etype_q[7:0], io.rx_data};
                        hcnt_q == OFF_VER_IHL:
                            ver_ihl_d = io.rx_data;
                        hcnt_q == OFF_PROTO:
                            proto_d = io.rx_data;
                        hcnt_q == OFF_DPORT,
                        hcnt_q == OFF_DPORT + 6'd1:
                            dport_d = {dport_q[7:0], io.rx_data};
                        hcnt_q == OFF_ULEN,
                        hcnt_q == OFF_ULEN + 6'd1:
                            ulen_d = {ulen_q[7:0], io.rx_data};
                        default: ;
                    endcase
                    if (hcnt_q == HDR_LEN - 6'd1) begin
                        hcnt_d = 6'd0;
                        if (hdr_ok) begin
                            state_d   = ST_PAYLOAD;
                            remain_d  = ulen_q - UDP_HDR_LEN;
                            sel_two_d = port_two;
                            inc_one   = port_one;
                            inc_two   = port_two;
                        end else begin
                            state_d  = ST_DRAIN;
                            inc_drop = 1'b1;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!io.rx_dv) begin
                    state_d  = ST_IDLE;
                    remain_d = 16'd0;
                    inc_runt = 1'b1;
                end else begin
                    remain_d  = remain_q - 16'd1;
                    ena_one_d = ~sel_two_q;
                    ena_two_d = sel_two_q;
                    if (remain_q == 16'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!io.rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            remain_q  <= '0;
            etype_q   <= '0;
            dport_q   <= '0;
            ulen_q    <= '0;
            ver_ihl_q <= '0;
            proto_q   <= '0;
            sel_two_q <= 1'b0;
            armed_q   <= 1'b0;
            dout_q    <= '0;
            ena_one_q <= 1'b0;
            ena_two_q <= 1'b0;
`ifdef DISPATCH_MAC_FILTER_EN
            mac_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            remain_q  <= remain_d;
            etype_q   <= etype_d;
            dport_q   <= dport_d;
            ulen_q    <= ulen_d;
            ver_ihl_q <= ver_ihl_d;
            proto_q   <= proto_d;
            sel_two_q <= sel_two_d;
            armed_q   <= armed_d;
            dout_q    <= dout_d;
            ena_one_q <= ena_one_d;
            ena_two_q <= ena_two_d;
`ifdef DISPATCH_MAC_FILTER_EN
            mac_q     <= mac_d;
`endif
        end
    end

    assign io.dout    = dout_q;
    assign io.ena_one = ena_one_q;
    assign io.ena_two = ena_two_q;

    our_sat_counter u_cnt_one (
        .clock (clock),
        .sclr  (sclr),
        .inc   (inc_one),
        .count (cnt_one)
    );

    our_sat_counter u_cnt_two (
        .clock (clock),
        .sclr  (sclr),
        .inc   (inc_two),
        .count (cnt_two)
    );

    our_sat_counter u_cnt_drop (
        .clock (clock),
        .sclr  (sclr),
        .inc   (inc_drop),
        .count (cnt_drop)
    );

    our_sat_counter u_cnt_runt (
        .clock (clock),
        .sclr  (sclr),
        .inc   (inc_runt),
        .count (cnt_runt)
    );

endmodule

// File: tb/tb_our_packet_dispatch.sv
// Directed and randomized frames against a frame-level reference model.
module tb_our_packet_dispatch;

    typedef logic [7:0] bq_t[$];

    localparam logic [47:0] MAC_LOCAL = 48'h0200_0000_0001;
    localparam logic [47:0] MAC_OTHER = 48'h0200_0000_0002;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    logic clock = 1'b0;
    logic sclr  = 1'b1;
    logic [15:0] cnt_one, cnt_two, cnt_drop, cnt_runt;

    int checks   = 0;
    int failures = 0;
    int exp_one  = 0;
    int exp_two  = 0;
    int exp_drop = 0;
    int exp_runt = 0;

    our_packet_dispatch_if bus ();

    our_packet_dispatch dut (
        .clock    (clock),
        .sclr     (sclr),
        .io       (bus.slave),
        .cnt_one  (cnt_one),
        .cnt_two  (cnt_two),
        .cnt_drop (cnt_drop),
        .cnt_runt (cnt_runt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic build_frame(output bq_t f, input logic [47:0] mac,
                               input logic [15:0] et, input logic [7:0] vih,
                               input logic [7:0] proto, input logic [15:0] dp,
                               input logic [15:0] ul, input int npay,
                               input int ntrail);
        f = {};
        for (int i = 0; i < 6; i++) f.push_back(mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
        f.push_back(et[15:8]);
        f.push_back(et[7:0]);
        f.push_back(vih);
        for (int i = 0; i < 8; i++) f.push_back(8'($urandom));
        f.push_back(proto);
        for (int i = 0; i < 12; i++) f.push_back(8'($urandom));
        f.push_back(dp[15:8]);
        f.push_back(dp[7:0]);
        f.push_back(ul[15:8]);
        f.push_back(ul[7:0]);
        f.push_back(8'($urandom));
        f.push_back(8'($urandom));
        for (int i = 0; i < npay + ntrail; i++) f.push_back(8'($urandom));
    endtask

    // kind: 0 dropped, 1 type ONE, 2 type TWO; plen = UDP payload length
    task automatic model(input bq_t f, output int kind, output int plen);
        logic [15:0] et, dp, ul;
        bit mac_ok;
        kind = 0;
        plen = 0;
        if (f.size() < 42) return;
        et = {f[12], f[13]};
        dp = {f[36], f[37]};
        ul = {f[38], f[39]};
        mac_ok = 1'b1;
`ifdef DISPATCH_MAC_FILTER_EN
        begin
            logic [47:0] mac;
            mac = {f[0], f[1], f[2], f[3], f[4], f[5]};
            mac_ok = (mac == MAC_LOCAL) || (mac == MAC_BCAST);
        end
`endif
        if (et == 16'h0800 && f[14] == 8'h45 && f[23] == 8'd17 &&
            ul > 16'd8 && mac_ok) begin
            if (dp == 16'd5001) kind = 1;
            else if (dp == 16'd5002) kind = 2;
        end
        if (kind != 0) plen = int'(ul) - 8;
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".cnt_one"}, 32'(cnt_one), exp_one);
        check({tag, ".cnt_two"}, 32'(cnt_two), exp_two);
        check({tag, ".cnt_drop"}, 32'(cnt_drop), exp_drop);
        check({tag, ".cnt_runt"}, 32'(cnt_runt), exp_runt);
    endtask

    task automatic send_frame(input string tag, input bq_t f, input int gap);
        int kind, plen, fwd, avail;
        int dout_bad, both, wrong, rises, first, pay_bad;
        logic prev;
        logic [7:0] cur;
        bq_t obs;
        model(f, kind, plen);
        avail = f.size() - 42;
        fwd = 0;
        if (kind != 0) fwd = (avail < plen) ? avail : plen;
        dout_bad = 0; both = 0; wrong = 0;
        rises = 0; first = -1; prev = 1'b0;
        obs = {};
        for (int i = 0; i < f.size() + gap; i++) begin
            if (i < f.size()) begin
                bus.rx_data = f[i];
                bus.rx_dv   = 1'b1;
            end else begin
                bus.rx_data = 8'($urandom);
                bus.rx_dv   = 1'b0;
            end
            cur = bus.rx_data;
            tick();
            if (bus.dout !== cur) dout_bad++;
            if (bus.ena_one === 1'b1 && bus.ena_two === 1'b1) both++;
            if (bus.ena_one === 1'b1 && kind != 1) wrong++;
            if (bus.ena_two === 1'b1 && kind != 2) wrong++;
            if ((bus.ena_one | bus.ena_two) === 1'b1) begin
                if (!prev) begin
                    rises++;
                    if (first < 0) first = i;
                end
                obs.push_back(bus.dout);
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
        pay_bad = 0;
        for (int k = 0; k < obs.size() && k < fwd; k++)
            if (obs[k] !== f[42+k]) pay_bad++;
        if (kind == 0) exp_drop = sat(exp_drop);
        if (kind == 1) exp_one = sat(exp_one);
        if (kind == 2) exp_two = sat(exp_two);
        if (kind != 0 && avail < plen) exp_runt = sat(exp_runt);
        check({tag, ".dout"}, dout_bad, 0);
        check({tag, ".ena_both"}, both, 0);
        check({tag, ".ena_type"}, wrong, 0);
        check({tag, ".nbytes"}, obs.size(), fwd);
        check({tag, ".payload"}, pay_bad, 0);
        check({tag, ".bursts"}, rises, (fwd > 0) ? 1 : 0);
        if (fwd > 0) check({tag, ".first"}, first, 42);
        check({tag, ".ena_end"}, {30'd0, bus.ena_one, bus.ena_two}, 0);
        check_counters(tag);
    endtask

    initial begin
        bq_t f;
        int r, npay, trail, gap, cut, cnt;
        logic [15:0] dp, ul, et;
        logic [7:0] vih, proto;
        logic [47:0] mac;

        bus.rx_data = 8'h00;
        bus.rx_dv   = 1'b0;
        sclr        = 1'b1;
        repeat (3) tick();
        sclr = 1'b0;
        tick();
        tick();
        check("rst.dout", 32'(bus.dout), 0);
        check("rst.ena_one", 32'(bus.ena_one), 0);
        check("rst.ena_two", 32'(bus.ena_two), 0);
        check_counters("rst");

        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5001,
                    16'd532, 524, 4);
        send_frame("one_fcs", f, 1);

        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5002,
                    16'd200, 192, 0);
        send_frame("b2b_two", f, 1);
        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5001,
                    16'd150, 142, 0);
        send_frame("b2b_one", f, 2);

        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd6, 16'd5001,
                    16'd100, 92, 4);
        send_frame("proto6", f, 1);
        build_frame(f, MAC_LOCAL, 16'h86DD, 8'h45, 8'd17, 16'd5002,
                    16'd100, 92, 4);
        send_frame("ipv6", f, 1);
        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5002,
                    16'd64, 56, 4);
        send_frame("after_drop", f, 1);

        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5001,
                    16'd532, 300, 0);
        send_frame("runt", f, 1);

        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5001,
                    16'd64, 56, 0);
        while (f.size() > 20) void'(f.pop_back());
        send_frame("short_hdr", f, 1);

        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5001,
                    16'd8, 0, 6);
        send_frame("ulen8", f, 1);
        build_frame(f, MAC_LOCAL, 16'h0800, 8'h46, 8'd17, 16'd5001,
                    16'd40, 32, 0);
        send_frame("ihl6", f, 1);
        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5003,
                    16'd40, 32, 0);
        send_frame("port5003", f, 1);
        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5002,
                    16'd9, 1, 4);
        send_frame("one_byte", f, 1);

        build_frame(f, MAC_OTHER, 16'h0800, 8'h45, 8'd17, 16'd5001,
                    16'd60, 52, 4);
        send_frame("mac_other", f, 1);
        build_frame(f, MAC_BCAST, 16'h0800, 8'h45, 8'd17, 16'd5002,
                    16'd60, 52, 4);
        send_frame("mac_bcast", f, 1);

        for (int n = 0; n < 24; n++) begin
            r  = $urandom_range(0, 9);
            dp = (r < 4) ? 16'd5001 : (r < 8) ? 16'd5002 : 16'd5003;
            ul = 16'($urandom_range(9, 120));
            npay  = int'(ul) - 8;
            trail = $urandom_range(0, 5);
            et = 16'h0800; vih = 8'h45; proto = 8'd17; mac = MAC_LOCAL;
            r = $urandom_range(0, 11);
            if (r == 0) et = 16'h0806;
            if (r == 1) vih = 8'h4F;
            if (r == 2) proto = 8'd1;
            if (r == 3) ul = 16'($urandom_range(0, 8));
            if (r == 4) mac = MAC_BCAST;
            if (r == 5) mac = {24'h0A0B0C, 24'($urandom)};
            if (r == 6) begin
                npay  = $urandom_range(0, npay - 1);
                trail = 0;
            end
            build_frame(f, mac, et, vih, proto, dp, ul, npay, trail);
            if (r == 7) begin
                cut = $urandom_range(1, 41);
                while (f.size() > cut) void'(f.pop_back());
            end
            gap = $urandom_range(1, 3);
            send_frame($sformatf("rand%0d", n), f, gap);
        end

        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5001,
                    16'd100, 92, 0);
        for (int i = 0; i < 50; i++) begin
            bus.rx_data = f[i];
            bus.rx_dv   = 1'b1;
            tick();
        end
        check("pre_sclr.cnt_one", 32'(cnt_one), sat(exp_one));
        bus.rx_data = f[50];
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        exp_one = 0; exp_two = 0; exp_drop = 0; exp_runt = 0;
        check("sclr.dout", 32'(bus.dout), 0);
        check("sclr.ena", {30'd0, bus.ena_one, bus.ena_two}, 0);
        check_counters("sclr");
        cnt = 0;
        for (int i = 51; i < f.size(); i++) begin
            bus.rx_data = f[i];
            tick();
            if (bus.ena_one !== 1'b0 || bus.ena_two !== 1'b0) cnt++;
        end
        bus.rx_dv = 1'b0;
        tick();
        tick();
        check("sclr.tail_ena", cnt, 0);
        check_counters("sclr_tail");
        build_frame(f, MAC_LOCAL, 16'h0800, 8'h45, 8'd17, 16'd5001,
                    16'd80, 72, 4);
        send_frame("post_sclr", f, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
